// File: rtl/tlc_pkg.sv
// Shared phase encoding for the traffic light controller and its lamp-side monitor.
// No logic of its own; constants and a helper used by both sides.
// No flow control involved.
package tlc_pkg;

    // Phase encoding shared with the controller: RED=0, YELLOW=1, GREEN=2, START=3.
    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2,
        START  = 2'd3
    } phase_t;

    // The only phase that may legally follow p.
    function automatic phase_t next_legal(input phase_t p);
        phase_t n;
        case (p)
            START:   n = RED;
            RED:     n = YELLOW;
            YELLOW:  n = GREEN;
            default: n = RED;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tlc_dwell_cnt.sv
// Saturating dwell counter: load-to-1 on a phase change, otherwise increment.
// Latency: one cycle from control to cnt.
// No backpressure; saturates at all-ones instead of wrapping.
module tlc_dwell_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load1,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    // Load has priority so the first sample of a new phase always counts as 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= CW'(1);
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tlc_monitor.sv
// Lamp-side monitor: decodes r/y/g into a phase, reports dwell per phase, counts cycles, flags faults.
// Latency: one cycle; a lamp change sampled at edge k shows on phase/dwell/dwell_vld after edge k.
// No backpressure; every sample is consumed, dwell_vld is a single-cycle pulse.
module tlc_monitor
    import tlc_pkg::*;
#(
    parameter int MIN_DWELL = 4,
    parameter int MAX_DWELL = 16,
    parameter int CW        = 8,
    parameter int NW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r,
    input  logic          y,
    input  logic          g,
    input  logic          clr,
    output logic [1:0]    phase,
    output logic [CW-1:0] dwell,
    output logic          dwell_vld,
    output logic [NW-1:0] cycles,
    output logic          err_multi,
    output logic          err_seq,
    output logic          err_dwell
);

    phase_t        state_q, state_d;
    phase_t        lamp_ph;
    logic          is_dark, is_multi, is_single;
    logic          load1, inc;
    logic          report, wrap;
    logic          set_multi, set_seq, set_dwell;
    logic [CW-1:0] cnt;
    logic [31:0]   cnt_ext;

    tlc_dwell_cnt #(.CW(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load1 (load1),
        .inc   (inc),
        .cnt   (cnt)
    );

    // Classify the current lamp sample; lamp_ph is meaningful only for a single lamp.
    always_comb begin
        is_dark   = !(r || y || g);
        is_multi  = (r && y) || (r && g) || (y && g);
        is_single = !is_dark && !is_multi;
        lamp_ph   = r ? RED : (y ? YELLOW : GREEN);
        cnt_ext   = 32'(cnt);
    end

    // Next phase, counter control and fault detection for this sample.
    always_comb begin
        state_d   = state_q;
        load1     = 1'b0;
        inc       = 1'b0;
        report    = 1'b0;
        wrap      = 1'b0;
        set_multi = 1'b0;
        set_seq   = 1'b0;
        set_dwell = 1'b0;
        if (is_multi) begin
            // Phase is held through a glitch; the glitch cycle counts toward dwell.
            set_multi = 1'b1;
            inc       = 1'b1;
        end else if (is_single && (lamp_ph != state_q)) begin
            state_d   = lamp_ph;
            load1     = 1'b1;
            report    = (state_q != START);
            set_dwell = report && ((cnt_ext < MIN_DWELL) || (cnt_ext > MAX_DWELL));
            set_seq   = (lamp_ph != next_legal(state_q));
            wrap      = (state_q == GREEN) && (lamp_ph == RED);
        end else if (is_dark && (state_q != START)) begin
            // Lamps went dark mid-cycle: restart tracking, no dwell is reported.
            state_d = START;
            load1   = 1'b1;
            set_seq = 1'b1;
        end else begin
            inc = 1'b1;
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= START;
        end else begin
            state_q <= state_d;
        end
    end

    // Reported dwell, cycle count and sticky flags; a new fault wins over clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell     <= '0;
            dwell_vld <= 1'b0;
            cycles    <= '0;
            err_multi <= 1'b0;
            err_seq   <= 1'b0;
            err_dwell <= 1'b0;
        end else begin
            dwell_vld <= report;
            if (report) begin
                dwell <= cnt;
            end
            if (clr) begin
                cycles <= '0;
            end else if (wrap) begin
                cycles <= cycles + 1'b1;
            end
            err_multi <= (err_multi && !clr) || set_multi;
            err_seq   <= (err_seq   && !clr) || set_seq;
            err_dwell <= (err_dwell && !clr) || set_dwell;
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_tlc_monitor.sv
module tb_tlc_monitor;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r = 1'b0, y = 1'b0, g = 1'b0, clr = 1'b0;

    logic [1:0]  phase0, phase1;
    logic [7:0]  dwell0;
    logic [3:0]  dwell1;
    logic        vld0, vld1;
    logic [15:0] cyc0, cyc1;
    logic        em0, es0, ed0, em1, es1, ed1;

    always #5 clk = ~clk;

    tlc_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .r(r), .y(y), .g(g), .clr(clr),
        .phase(phase0), .dwell(dwell0), .dwell_vld(vld0), .cycles(cyc0),
        .err_multi(em0), .err_seq(es0), .err_dwell(ed0)
    );

    tlc_monitor #(.MIN_DWELL(4), .MAX_DWELL(12), .CW(4), .NW(16)) u_sat (
        .clk(clk), .rst_n(rst_n), .r(r), .y(y), .g(g), .clr(clr),
        .phase(phase1), .dwell(dwell1), .dwell_vld(vld1), .cycles(cyc1),
        .err_multi(em1), .err_seq(es1), .err_dwell(ed1)
    );

    typedef struct packed {
        logic [1:0]  phase;
        logic [7:0]  dwell;
        logic        vld;
        logic [15:0] cycles;
        logic        em;
        logic        es;
        logic        ed;
    } obs_t;

    // Reference model: one entry per DUT instance.
    obs_t exp_o [2];
    int   m_cnt [2];
    int   cmax  [2] = '{255, 15};
    int   mmin  [2] = '{4, 4};
    int   mmax  [2] = '{16, 12};

    int checks = 0;
    int errors = 0;

    function automatic obs_t observed(input int k);
        obs_t o;
        if (k == 0) begin
            o.phase = phase0; o.dwell = dwell0; o.vld = vld0; o.cycles = cyc0;
            o.em = em0; o.es = es0; o.ed = ed0;
        end else begin
            o.phase = phase1; o.dwell = {4'b0000, dwell1}; o.vld = vld1; o.cycles = cyc1;
            o.em = em1; o.es = es1; o.ed = ed1;
        end
        return o;
    endfunction

    function automatic logic [2:0] lamp(input int p);
        logic [2:0] l;
        case (p)
            0:       l = L_RED;
            1:       l = L_YEL;
            default: l = L_GRN;
        endcase
        return l;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_o[k] = '0;
            exp_o[k].phase = 2'd3;
            m_cnt[k] = 0;
        end
    endtask

    // Phase follows the single lit lamp; runs are measured in samples.
    task automatic model_edge(input logic [2:0] l, input logic c);
        int n;
        int lp;
        n  = $countones(l);
        lp = l[2] ? 0 : (l[1] ? 1 : 2);
        for (int k = 0; k < 2; k++) begin
            int ph;
            ph = int'(exp_o[k].phase);
            exp_o[k].vld = 1'b0;
            if (c) begin
                exp_o[k].em = 1'b0; exp_o[k].es = 1'b0; exp_o[k].ed = 1'b0;
                exp_o[k].cycles = '0;
            end
            if (n >= 2) begin
                exp_o[k].em = 1'b1;
                m_cnt[k] = (m_cnt[k] < cmax[k]) ? m_cnt[k] + 1 : cmax[k];
            end else if (n == 0 && ph != 3) begin
                exp_o[k].es = 1'b1;
                exp_o[k].phase = 2'd3;
                m_cnt[k] = 1;
            end else if (n == 0 || lp == ph) begin
                m_cnt[k] = (m_cnt[k] < cmax[k]) ? m_cnt[k] + 1 : cmax[k];
            end else begin
                if (ph != 3) begin
                    exp_o[k].dwell = 8'(m_cnt[k]);
                    exp_o[k].vld = 1'b1;
                    if (m_cnt[k] < mmin[k] || m_cnt[k] > mmax[k]) exp_o[k].ed = 1'b1;
                end
                if (!((ph == 3 && lp == 0) || (ph != 3 && lp == (ph + 1) % 3)))
                    exp_o[k].es = 1'b1;
                if (ph == 2 && lp == 0 && !c)
                    exp_o[k].cycles = exp_o[k].cycles + 16'd1;
                exp_o[k].phase = 2'(lp);
                m_cnt[k] = 1;
            end
        end
    endtask

    task automatic step(input logic [2:0] l, input logic c);
        {r, y, g} = l;
        clr = c;
        @(posedge clk);
        model_edge(l, c);
        #1;
    endtask

    task automatic hold(input logic [2:0] l, input int n);
        repeat (n) step(l, 1'b0);
    endtask

    task automatic apply_reset();
        {r, y, g} = L_OFF;
        clr = 1'b0;
        rst_n = 1'b0;
        #3;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t o;
        #12;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            o = observed(k);
            checks++;
            if (o !== {2'd3, 8'd0, 1'b0, 16'd0, 3'b000}) begin
                errors++;
                $display("FAIL reset_state[%0d]: got %h, expected phase 3 and all zero", k, o);
            end
        end
        rst_n = 1'b1;
        hold(L_OFF, 3);
        checks++;
        if ({phase0, vld0, em0, es0, ed0} !== {2'd3, 4'b0000}) begin
            errors++;
            $display("FAIL dark_in_start: phase=%0d vld=%b err=%b%b%b, expected 3 and no flags",
                     phase0, vld0, em0, es0, ed0);
        end
    endtask

    task automatic test_legal_loop();
        obs_t o;
        apply_reset();
        for (int rep = 0; rep < 2; rep++) begin
            for (int p = 0; p < 3; p++) begin
                for (int i = 0; i < 6; i++) begin
                    step(lamp(p), 1'b0);
                    if (i == 0 && !(rep == 0 && p == 0)) begin
                        checks++;
                        if ({vld0, dwell0} !== {1'b1, 8'd6}) begin
                            errors++;
                            $display("FAIL loop_dwell rep%0d ph%0d: vld=%b dwell=%0d, expected 1/6",
                                     rep, p, vld0, dwell0);
                        end
                    end
                end
            end
        end
        step(L_RED, 1'b0);
        checks++;
        if ({vld0, dwell0, cyc0, em0, es0, ed0, cyc1} !== {1'b1, 8'd6, 16'd2, 3'b000, 16'd2}) begin
            errors++;
            $display("FAIL loop_end: vld=%b dwell=%0d cycles=%0d/%0d err=%b%b%b, expected 1 6 2/2 000",
                     vld0, dwell0, cyc0, cyc1, em0, es0, ed0);
        end
        for (int k = 0; k < 2; k++) begin
            o = observed(k);
            checks++;
            if (o !== exp_o[k]) begin
                errors++;
                $display("FAIL loop_model[%0d]: got %h, expected %h", k, o, exp_o[k]);
            end
        end
    endtask

    task automatic test_short_phase();
        apply_reset();
        hold(L_RED, 6);
        hold(L_YEL, 2);
        step(L_GRN, 1'b0);
        checks++;
        if ({vld0, dwell0, ed0, ed1, es0} !== {1'b1, 8'd2, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL short_dwell: vld=%b dwell=%0d err_dwell=%b/%b err_seq=%b, expected 1 2 1/1 0",
                     vld0, dwell0, ed0, ed1, es0);
        end
        hold(L_GRN, 4);
        checks++;
        if (ed0 !== 1'b1) begin
            errors++;
            $display("FAIL short_sticky: err_dwell=%b, expected 1", ed0);
        end
        step(L_GRN, 1'b1);
        checks++;
        if ({ed0, ed1, em0, es0} !== 4'b0000) begin
            errors++;
            $display("FAIL short_clr: err_dwell=%b/%b em=%b es=%b, expected all 0", ed0, ed1, em0, es0);
        end
    endtask

    task automatic test_illegal_order();
        apply_reset();
        hold(L_RED, 6); hold(L_YEL, 6); hold(L_GRN, 6); hold(L_RED, 6);
        step(L_GRN, 1'b0);
        checks++;
        if ({es0, phase0, vld0, dwell0, cyc0} !== {1'b1, 2'd2, 1'b1, 8'd6, 16'd1}) begin
            errors++;
            $display("FAIL illegal_order: es=%b phase=%0d vld=%b dwell=%0d cycles=%0d, expected 1 2 1 6 1",
                     es0, phase0, vld0, dwell0, cyc0);
        end
        checks++;
        if (observed(1) !== exp_o[1]) begin
            errors++;
            $display("FAIL illegal_model[1]: got %h, expected %h", observed(1), exp_o[1]);
        end
    endtask

    task automatic test_multi();
        apply_reset();
        hold(L_RED, 3);
        step(3'b110, 1'b0);
        checks++;
        if ({em0, em1, phase0, vld0} !== {1'b1, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL multi_flag: em=%b/%b phase=%0d vld=%b, expected 1/1 0 0", em0, em1, phase0, vld0);
        end
        hold(L_RED, 2);
        step(L_YEL, 1'b0);
        checks++;
        if ({vld0, dwell0, dwell1, em0, es0, ed0} !== {1'b1, 8'd6, 4'd6, 3'b100}) begin
            errors++;
            $display("FAIL multi_dwell: vld=%b dwell=%0d/%0d err=%b%b%b, expected 1 6/6 100",
                     vld0, dwell0, dwell1, em0, es0, ed0);
        end
    endtask

    task automatic test_saturation_dark();
        apply_reset();
        hold(L_RED, 20);
        step(L_YEL, 1'b0);
        checks++;
        if ({vld1, dwell1, ed1, dwell0, ed0} !== {1'b1, 4'd15, 1'b1, 8'd20, 1'b1}) begin
            errors++;
            $display("FAIL saturation: vld=%b dwell=%0d err_dwell=%b (cw4), dwell=%0d err_dwell=%b (cw8), expected 1 15 1, 20 1",
                     vld1, dwell1, ed1, dwell0, ed0);
        end
        hold(L_YEL, 5);
        step(L_OFF, 1'b0);
        checks++;
        if ({phase0, phase1, es0, es1, vld0} !== {2'd3, 2'd3, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL dark_fault: phase=%0d/%0d es=%b/%b vld=%b, expected 3/3 1/1 0",
                     phase0, phase1, es0, es1, vld0);
        end
    endtask

    task automatic test_reset_mid_phase();
        obs_t o;
        apply_reset();
        hold(L_RED, 6); hold(L_YEL, 6); hold(L_GRN, 6); hold(L_RED, 2);
        step(3'b011, 1'b0);
        hold(L_RED, 3); hold(L_YEL, 6); hold(L_GRN, 3);
        checks++;
        if ({cyc0, em0, phase0} !== {16'd1, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL pre_reset: cycles=%0d em=%b phase=%0d, expected 1 1 2", cyc0, em0, phase0);
        end
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            o = observed(k);
            checks++;
            if (o !== {2'd3, 8'd0, 1'b0, 16'd0, 3'b000}) begin
                errors++;
                $display("FAIL async_reset[%0d]: got %h, expected phase 3 and all zero", k, o);
            end
        end
        model_reset();
        rst_n = 1'b1;
        hold(L_RED, 6);
        step(L_YEL, 1'b0);
        checks++;
        if ({vld0, dwell0, em0, es0, ed0, em1, es1, ed1} !== {1'b1, 8'd6, 6'b000000}) begin
            errors++;
            $display("FAIL after_reset: vld=%b dwell=%0d err=%b%b%b/%b%b%b, expected 1 6 no flags",
                     vld0, dwell0, em0, es0, ed0, em1, es1, ed1);
        end
    endtask

    task automatic test_random();
        int cur_p;
        int cyc;
        int kind;
        int len;
        logic [2:0] l;
        logic c;
        logic [2:0] mpat;
        obs_t o;
        apply_reset();
        cur_p = 2;
        cyc = 0;
        while (cyc < 3000) begin
            kind = $urandom_range(0, 99);
            len  = $urandom_range(1, 20);
            if (kind < 70) begin
                cur_p = (cur_p + 1) % 3;
                l = lamp(cur_p);
            end else if (kind < 78) begin
                l = L_OFF;
                len = $urandom_range(1, 3);
                cur_p = 2;
            end else if (kind < 86) begin
                cur_p = $urandom_range(0, 2);
                l = lamp(cur_p);
            end else if (kind < 94) begin
                mpat = 3'(3 + $urandom_range(0, 3));
                l = (mpat == 3'd4) ? 3'b111 : mpat;
                len = $urandom_range(1, 2);
            end else begin
                l = lamp(cur_p);
                len = 1;
            end
            for (int i = 0; i < len; i++) begin
                c = ($urandom_range(0, 39) == 0) || (kind >= 94);
                step(l, c);
                cyc++;
                for (int k = 0; k < 2; k++) begin
                    o = observed(k);
                    checks++;
                    if (o !== exp_o[k]) begin
                        errors++;
                        $display("FAIL random[%0d] cyc %0d lamps %b clr %b: got %h, expected %h",
                                 k, cyc, l, c, o, exp_o[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_legal_loop();
        test_short_phase();
        test_illegal_order();
        test_multi();
        test_saturation_dark();
        test_reset_mid_phase();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlc_monitor.md
# tlc_monitor

Lamp-side monitor for the traffic light controller: it watches the three lamp lines `r`, `y` and `g` and recovers the current phase. It measures how long each phase lasted, counts complete red-yellow-green cycles, and raises sticky fault flags on illegal lamp patterns, illegal phase order or out-of-range dwell times. It sits on the controller's lamp outputs in the same clock domain and feeds status and fault reporting.

## Interface
Parameters:
- `MIN_DWELL`, default 4: minimum legal phase length, in clock cycles.
- `MAX_DWELL`, default 16: maximum legal phase length, in clock cycles.
- `CW`, default 8: width of the dwell counter and the dwell output.
- `NW`, default 16: width of the cycle counter.

Ports (clock and reset first):
- `clk`  in  1: single clock. All logic is on the posedge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `r`  in  1: red lamp line from the controller (synchronous to `clk`).
- `y`  in  1: yellow lamp line (synchronous to `clk`).
- `g`  in  1: green lamp line (synchronous to `clk`).
- `clr`  in  1: synchronous clear of the three error flags and the cycle counter.
- `phase`  out  2: current decoded phase: 0 red, 1 yellow, 2 green, 3 start/dark.
- `dwell`  out  CW: length of the last completed phase.
- `dwell_vld`  out  1: one-cycle pulse when `dwell` updates.
- `cycles`  out  NW: count of completed green-to-red wraps.
- `err_multi`  out  1: sticky; more than one lamp was high.
- `err_seq`  out  1: sticky; illegal phase transition.
- `err_dwell`  out  1: sticky; a completed phase length was outside MIN_DWELL..MAX_DWELL.

## Operation
- Each posedge samples `{r,y,g}` and classifies the sample:
  - dark: all lamps low.
  - single: exactly one lamp high.
  - multi: two or more lamps high.
- State is `phase` (start/red/yellow/green) plus a dwell counter `cnt`. The counter saturates at 2^CW-1.
- Sample equals the current phase's lamp, or sample is dark while in start: `cnt` increments, saturating.
- Sample is a single lamp different from the current phase:
  - `phase` takes the new lamp and `cnt` is set to 1.
  - If the old phase was not start: `dwell` takes the old `cnt` and `dwell_vld` pulses.
  - `err_dwell` is set if the old `cnt` is below MIN_DWELL or above MAX_DWELL. It is never checked for the start phase.
- Legal transitions: start→red, red→yellow, yellow→green, green→red. Any other single-lamp change sets `err_seq`; the phase is still followed.
- A green→red transition increments `cycles`, which wraps at 2^NW.
- Multi sample: sets `err_multi`. `phase` is unchanged and `cnt` still increments.
- Dark sample while in red, yellow or green: sets `err_seq`. `phase` moves to start, `cnt` is set to 1, and no `dwell_vld` pulse is issued.
- `clr` clears all three error flags and `cycles` on that edge. If an error occurs on the same edge, the new error wins and its flag is set.

## Timing
- Reset values: `phase`=3, `cnt`=0, `dwell`=0, `dwell_vld`=0, `cycles`=0, all `err_*`=0.
- Latency: one cycle. A lamp change sampled at edge k is visible on `phase`, `dwell` and `dwell_vld` right after edge k.
- Dwell counts samples. If red is high for edges k..k+5 and yellow is first seen at edge k+6, then `dwell`=6 with `dwell_vld` high for one cycle after edge k+6.
- `dwell_vld` never stays high two cycles in a row unless the phase changes on two consecutive edges.
- Reset asserted mid-phase returns every output to its reset value immediately. The first phase after release is measured from start, with no dwell check.
- Saturation: `cnt` holds at 2^CW-1. A saturated dwell reports 2^CW-1 and, with the defaults, sets `err_dwell`.

## Structure
- Shared package `tlc_pkg`:
  - phase encoding constants RED=0, YELLOW=1, GREEN=2, START=3, also used by the controller;
  - a 2-bit phase typedef.
- One sub-module, `tlc_dwell_cnt`: a CW-bit saturating counter with load-1 and increment controls.
- Everything else (classifier, phase register, checks, counters) lives in `tlc_monitor`.

## Test plan
- Legal loop: reset, then red 6 / yellow 6 / green 6 cycles, repeated twice → `dwell` = 6, 6, 6, 6, 6, 6; `cycles` = 2; no errors.
- Short phase: red 6, yellow 2, green 6 → `dwell_vld` with `dwell`=2 and `err_dwell`=1. `err_dwell` stays 1 until `clr`, then reads 0.
- Illegal order: red 6 then green → `err_seq`=1, `phase`=2, `dwell`=6, `cycles` unchanged.
- Multi-lamp: `r` and `y` both high for 1 cycle inside red → `err_multi`=1, `phase` stays 0, red `dwell` includes that cycle.
- Saturation and dark: with CW=4, red for 20 cycles then yellow → `dwell`=15, `err_dwell`=1. Then all lamps dark → `phase`=3, `err_seq`=1.
- Reset mid-phase: pull `rst_n` low during green → `phase`=3 and every counter and flag is 0 immediately. After release, red 6 then yellow 6 → `dwell`=6, no errors.
